// File: rtl/int_gen_pkg.sv
// Shared definitions for the interrupt generator: register offsets, mode codes,
// FSM state encoding and the byte-lane merge helper used by bus-writable registers.
package int_gen_pkg;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PERIOD = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_ACK    = 3'd4;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/int_gen_counter.sv
// 32-bit down-counter with synchronous load, decrement that stops at zero,
// and a combinational expire pulse on the 1 -> 0 step.
module int_gen_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        dec_i,
  output logic [31:0] count_o,
  output logic        expire_o
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != 32'd0)) begin
      count_d = count_q - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) count_q <= 32'd0;
    else        count_q <= count_d;
  end

  assign count_o  = count_q;
  assign expire_o = dec_i && (count_q == 32'd1);

endmodule

// File: rtl/int_gen.sv
// Memory-mapped interrupt generator: register file, address decode and run/hold FSM
// around a down-counter; IRQ holds until acknowledged, missed expiries counted as overrun.
module int_gen
  import int_gen_pkg::*;
#(
  parameter logic [31:0] PERIOD_RST = 32'd0,
  parameter int          OVR_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic [3:0]  ByteEn,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  state_e             state_q, state_d;
  logic [2:0]         ctrl_q;
  logic [31:0]        period_q;
  logic               pending_q, pending_d;
  logic [OVR_W-1:0]   ovr_q, ovr_d;
  logic [31:0]        count_w;
  logic               expire_w, cnt_load, cnt_dec;

  logic [2:0] off_w;
  logic       wr_w, ctrl_wr, en_wr, dis_wr, ack_wr, status_wr, periodic_w;
  logic       unused_addr;

  assign off_w       = Addr[4:2];
  assign unused_addr = ^{Addr[29:5], Addr[1:0]};
  assign wr_w        = |ByteEn;
  // EN/MODE live in byte 0, so a CTRL write only counts when that lane is enabled
  assign ctrl_wr     = wr_w && (off_w == OFF_CTRL) && ByteEn[0];
  assign en_wr       = ctrl_wr && Din[0];
  assign dis_wr      = ctrl_wr && !Din[0];
  assign ack_wr      = wr_w && (off_w == OFF_ACK);
  assign status_wr   = wr_w && (off_w == OFF_STATUS);
  assign periodic_w  = (ctrl_q[2:1] == MODE_PERIODIC);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q    <= 3'd0;
      period_q  <= PERIOD_RST;
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      ovr_q     <= '0;
    end else begin
      if (ctrl_wr) ctrl_q <= Din[2:0];
      if (wr_w && (off_w == OFF_PERIOD)) period_q <= byte_merge(period_q, Din, ByteEn);
      state_q   <= state_d;
      pending_q <= pending_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (en_wr && (period_q != 32'd0)) begin
          cnt_load = 1'b1;
          state_d  = ST_RUN;
        end else if (ctrl_wr) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (dis_wr) begin
          state_d = ST_IDLE;
        end else if (count_w == 32'd0) begin
          // periodic reload cycle: picks up whatever PERIOD holds now
          cnt_load = 1'b1;
        end else begin
          cnt_dec = 1'b1;
          if ((count_w == 32'd1) && !periodic_w) state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    ovr_d     = ovr_q;
    if (expire_w) begin
      // an expiry beats a same-cycle ACK and is then not counted as missed
      if (!pending_q) pending_d = 1'b1;
      else if (!ack_wr && (ovr_q != {OVR_W{1'b1}})) ovr_d = ovr_q + OVR_W'(1);
    end else if (ack_wr) begin
      pending_d = 1'b0;
    end
    if (status_wr) ovr_d = '0;
  end

  int_gen_counter u_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (period_q),
    .dec_i      (cnt_dec),
    .count_o    (count_w),
    .expire_o   (expire_w)
  );

  always_comb begin
    Dout = 32'd0;
    case (off_w)
      OFF_CTRL:   Dout = {29'd0, ctrl_q};
      OFF_PERIOD: Dout = period_q;
      OFF_COUNT:  Dout = count_w;
      OFF_STATUS: Dout = (32'(ovr_q) << 8) | {31'd0, pending_q};
      default:    Dout = 32'd0;
    endcase
  end

  assign IRQ = pending_q;

endmodule
